// File: rtl/block_assign_pkg.sv
// Shared constants for block_assign_pipe: default operand and counter widths,
// plus the pipeline depth. The depth is also the number of rising edges from
// input acceptance to a valid result when the consumer is always ready.
package block_assign_pkg;

    localparam int BAP_WIDTH  = 8;
    localparam int BAP_CNT_W  = 16;
    localparam int PIPE_DEPTH = 2;

endpackage : block_assign_pkg

// File: rtl/block_assign_stage.sv
// One valid-tagged register stage. When ld is high, the valid flag follows
// valid_in. The data register captures data_in only when the incoming word is
// valid. This keeps the data stable across bubbles. Reset is synchronous and
// active high.
module block_assign_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          valid_q,
    output logic [DW-1:0] data_q
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // Valid flag and data register, with reset taking priority over ld.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (ld) begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_data <= data_in;
            end
        end
    end

    assign valid_q = r_valid;
    assign data_q  = r_data;

endmodule : block_assign_stage

// File: rtl/block_assign_pipe.sv
// block_assign_pipe: y = (a & b) | (c ^ d) in two registered stages, with a
// valid/ready handshake on both sides.
// Stage 1 holds {a & b, c ^ d}. Stage 2 holds their OR.
// The pipeline can hold at most two results, one per stage.
// in_ready depends combinationally on out_ready, so a full pipeline can
// accept a new input in the same cycle that it delivers a result.
// Optional feature: define BLOCK_ASSIGN_PIPE_CNT_EN to add a CNT_W-bit count
// of delivered results on the result_cnt output. The count wraps.
module block_assign_pipe
    import block_assign_pkg::*;
#(
    parameter int WIDTH = BAP_WIDTH
`ifdef BLOCK_ASSIGN_PIPE_CNT_EN
    ,
    parameter int CNT_W = BAP_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
`ifdef BLOCK_ASSIGN_PIPE_CNT_EN
    ,
    output logic [CNT_W-1:0] result_cnt
`endif
);

    logic               w_s1_valid;
    logic [2*WIDTH-1:0] w_s1_din;
    logic [2*WIDTH-1:0] w_s1_data;
    logic [WIDTH-1:0]   w_s2_din;
    logic               w_s2_ld;

    // Stage 2 can load when it is empty or when its result leaves this cycle.
    // Stage 1 can load when it is empty or when stage 2 takes its content.
    assign w_s2_ld  = ~out_valid | out_ready;
    assign in_ready = ~w_s1_valid | w_s2_ld;

    assign w_s1_din = {a & b, c ^ d};
    assign w_s2_din = w_s1_data[2*WIDTH-1:WIDTH] | w_s1_data[WIDTH-1:0];

    block_assign_stage #(.DW(2 * WIDTH)) u_stage1 (
        .clk      (clk),
        .rst      (rst),
        .ld       (in_ready),
        .valid_in (in_valid),
        .data_in  (w_s1_din),
        .valid_q  (w_s1_valid),
        .data_q   (w_s1_data)
    );

    block_assign_stage #(.DW(WIDTH)) u_stage2 (
        .clk      (clk),
        .rst      (rst),
        .ld       (w_s2_ld),
        .valid_in (w_s1_valid),
        .data_in  (w_s2_din),
        .valid_q  (out_valid),
        .data_q   (y)
    );

    assign busy = w_s1_valid | out_valid;

`ifdef BLOCK_ASSIGN_PIPE_CNT_EN
    logic [CNT_W-1:0] r_result_cnt;

    // Count output transfers. The counter wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_cnt <= '0;
        end else if (out_valid & out_ready) begin
            r_result_cnt <= r_result_cnt + CNT_W'(1);
        end
    end

    assign result_cnt = r_result_cnt;
`endif

endmodule : block_assign_pipe

// File: tb/tb_block_assign_pipe.sv
// Directed bench for block_assign_pipe with WIDTH=8.
// Counter checks are included when BLOCK_ASSIGN_PIPE_CNT_EN is defined, and
// then use CNT_W=4.
module tb_block_assign_pipe;
    import block_assign_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] y;
    logic         busy;
`ifdef BLOCK_ASSIGN_PIPE_CNT_EN
    logic [3:0]   result_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] exp_q [0:9];
    logic [W-1:0] bp_exp [0:2];

    block_assign_pipe #(
        .WIDTH (W)
`ifdef BLOCK_ASSIGN_PIPE_CNT_EN
        ,
        .CNT_W (4)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
`ifdef BLOCK_ASSIGN_PIPE_CNT_EN
        ,
        .result_cnt(result_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_y(input logic [W-1:0] ra, rb, rc, rd);
        return (ra & rb) | (rc ^ rd);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [W-1:0] ra, rb, rc, rd);
        a = ra; b = rb; c = rc; d = rd;
    endtask

    initial begin
        // Reset with in_valid high. Nothing may leak out.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive(8'hFF, 8'hFF, 8'h0F, 8'hF0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_y", {24'd0, y}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef BLOCK_ASSIGN_PIPE_CNT_EN
            check("rst_cnt", {28'd0, result_cnt}, 32'd0);
`endif
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_out_valid", {31'd0, out_valid}, 32'd0);

        // Single transfer and its latency.
        drive(8'hF0, 8'h3C, 8'hAA, 8'h55);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("single_in_ready", {31'd0, in_ready}, 32'd1);
        tick();                         // acceptance edge
        in_valid = 1'b0;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            check("single_early_valid", {31'd0, out_valid}, 32'd0);
            check("single_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        check("single_out_valid", {31'd0, out_valid}, 32'd1);
        check("single_y", {24'd0, y}, 32'hFF);
        tick();
        check("single_done_valid", {31'd0, out_valid}, 32'd0);
        check("single_done_busy", {31'd0, busy}, 32'd0);

        // Stream of 10 random vectors at full throughput.
        for (int i = 0; i < 10; i++) begin
            drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            exp_q[i] = ref_y(a, b, c, d);
            in_valid = 1'b1;
            #1;
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            if (i >= 1) begin
                check("stream_valid", {31'd0, out_valid}, 32'd1);
                check("stream_y", {24'd0, y}, {24'd0, exp_q[i-1]});
            end
        end
        in_valid = 1'b0;
        tick();
        check("stream_last_valid", {31'd0, out_valid}, 32'd1);
        check("stream_last_y", {24'd0, y}, {24'd0, exp_q[9]});
        tick();
        check("stream_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure: two inputs are accepted, the third waits.
        out_ready = 1'b0;
        drive(8'h12, 8'h34, 8'h56, 8'h78); bp_exp[0] = 8'h3E; // 10 | 2E
        in_valid = 1'b1;
        tick();
        drive(8'hFF, 8'h0F, 8'hF0, 8'hF0); bp_exp[1] = 8'h0F; // 0F | 00
        #1;
        check("bp_in_ready_2nd", {31'd0, in_ready}, 32'd1);
        tick();
        drive(8'h80, 8'h81, 8'h01, 8'h02); bp_exp[2] = 8'h83; // 80 | 03
        #1;
        check("bp_in_ready_3rd", {31'd0, in_ready}, 32'd0);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_y0", {24'd0, y}, {24'd0, bp_exp[0]});
        tick();
        tick();
        check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_y", {24'd0, y}, {24'd0, bp_exp[0]});
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_drain_y1", {24'd0, y}, {24'd0, bp_exp[1]});
        tick();
        check("bp_drain_valid2", {31'd0, out_valid}, 32'd1);
        check("bp_drain_y2", {24'd0, y}, {24'd0, bp_exp[2]});
        tick();
        check("bp_drain_empty", {31'd0, out_valid}, 32'd0);
`ifdef BLOCK_ASSIGN_PIPE_CNT_EN
        check("cnt_after_bp", {28'd0, result_cnt}, 32'd14);
`endif

        // Reset with both stages full.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(8'hAA, 8'hFF, 8'h00, 8'h00);
        tick();
        tick();
        check("full_busy", {31'd0, busy}, 32'd1);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
            check("mid_rst_busy", {31'd0, busy}, 32'd0);
            tick();
        end
        check("mid_rst_y", {24'd0, y}, 32'd0);
`ifdef BLOCK_ASSIGN_PIPE_CNT_EN
        check("mid_rst_cnt", {28'd0, result_cnt}, 32'd0);

        // Deliver 17 results. A 4-bit counter wraps to 1.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(W'(i), 8'hFF, 8'h00, 8'h00);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("cnt_wrap", {28'd0, result_cnt}, 32'd1);
        check("cnt_wrap_idle", {31'd0, busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_block_assign_pipe
